// File: rtl/vrf_read_group_sequencer_pkg.sv
// Shared types for the VRF read group sequencer and the read pipe.
// State enum, request/output bundles and the outstanding-read limit.
package vrf_read_group_sequencer_pkg;

  localparam int DATA_W  = 32;
  localparam int VS_W    = 5;
  localparam int GROUP_W = 4;
  localparam int SRC_W   = 4;
  localparam int INST_W  = 3;

  // Read-pipe data queue depth; outstanding reads must never exceed it.
  localparam int PIPE_QUEUE_DEPTH    = 4;
  localparam int MAX_OUTSTANDING_DEF = PIPE_QUEUE_DEPTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } seq_state_e;

  typedef struct packed {
    logic [VS_W-1:0]    vs;
    logic [GROUP_W-1:0] group_index;
    logic [SRC_W-1:0]   read_source;
    logic [INST_W-1:0]  instruction_index;
  } vrf_read_req_t;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [GROUP_W-1:0] group_index;
    logic               last;
    logic [INST_W-1:0]  instruction_index;
  } vrf_read_out_t;

endpackage

// File: rtl/vrf_read_group_sequencer_credit.sv
// Up/down credit counter bounding issued-but-not-returned reads.
// Ports: clock, reset, i_inc (issue), i_dec (return), o_count, o_has_credit.
module vrf_read_credit_counter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_has_credit
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && !i_dec) begin
      r_count <= r_count + 1'b1;
    end else if (i_dec && !i_inc) begin
      r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(i_inc && !i_dec &&
                r_count == CNT_W'(MAX_OUTSTANDING)));
      assert (!(i_dec && !i_inc && r_count == '0));
    end
  end

  assign o_count      = r_count;
  assign o_has_credit = r_count < CNT_W'(MAX_OUTSTANDING);

endmodule

// File: rtl/vrf_read_group_sequencer.sv
// Walks groups 0..last of one VRF read, issuing pipe requests and tagging returns.
// Ports: inst_* offer, req_* to pipe enqueue, rdata_* from pipe, out_* tagged words, done.
module vrf_read_group_sequencer
  import vrf_read_group_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_W,
  parameter int VS_WIDTH        = VS_W,
  parameter int GROUP_WIDTH     = GROUP_W,
  parameter int SRC_WIDTH       = SRC_W,
  parameter int INST_WIDTH      = INST_W,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   inst_valid,
  output logic                   inst_ready,
  input  logic [VS_WIDTH-1:0]    inst_vs,
  input  logic [GROUP_WIDTH-1:0] inst_last_group,
  input  logic [SRC_WIDTH-1:0]   inst_read_source,
  input  logic [INST_WIDTH-1:0]  inst_instruction_index,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [VS_WIDTH-1:0]    req_vs,
  output logic [GROUP_WIDTH-1:0] req_group_index,
  output logic [SRC_WIDTH-1:0]   req_read_source,
  output logic [INST_WIDTH-1:0]  req_instruction_index,
  input  logic                   rdata_valid,
  output logic                   rdata_ready,
  input  logic [DATA_WIDTH-1:0]  rdata_bits,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [GROUP_WIDTH-1:0] out_group_index,
  output logic                   out_last,
  output logic [INST_WIDTH-1:0]  out_instruction_index,
  output logic                   done
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  seq_state_e       r_state;
  seq_state_e       w_next;
  // group_index of the latch holds the final group index.
  vrf_read_req_t    r_inst;
  logic [GROUP_WIDTH-1:0] r_issue_ptr;
  logic [GROUP_WIDTH-1:0] r_ret_ptr;
  vrf_read_out_t    r_out;
  logic             r_out_valid;
  logic             r_done;

  logic             w_req_valid;
  logic             w_inst_ready;
  logic             w_has_credit;
  logic [CNT_W-1:0] w_credit;
  logic             w_inst_fire;
  logic             w_req_fire;
  logic             w_rd_fire;
  logic             w_out_fire;
  logic             w_issue_last;
  logic             w_final_out;

  assign w_inst_fire  = inst_valid & w_inst_ready;
  assign w_req_fire   = w_req_valid & req_ready;
  assign w_rd_fire    = rdata_valid & rdata_ready;
  assign w_out_fire   = r_out_valid & out_ready;
  assign w_issue_last = r_issue_ptr == r_inst.group_index;
  assign w_final_out  = w_out_fire & r_out.last &
                        (r_state == ST_DRAIN);

  vrf_read_credit_counter #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .CNT_W          (CNT_W)
  ) u_credit (
    .clock       (clock),
    .reset       (reset),
    .i_inc       (w_req_fire),
    .i_dec       (w_rd_fire),
    .o_count     (w_credit),
    .o_has_credit(w_has_credit)
  );

  always_comb begin
    w_next       = r_state;
    w_req_valid  = 1'b0;
    w_inst_ready = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // Hold off during the done pulse.
        w_inst_ready = ~r_done;
        if (inst_valid && !r_done) w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_req_valid = w_has_credit;
        if (w_has_credit && req_ready && w_issue_last)
          w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_final_out) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_inst      <= '0;
      r_issue_ptr <= '0;
      r_ret_ptr   <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_final_out;
      if (w_inst_fire) begin
        r_inst <= '{vs:                inst_vs,
                    group_index:       inst_last_group,
                    read_source:       inst_read_source,
                    instruction_index: inst_instruction_index};
        r_issue_ptr <= '0;
        r_ret_ptr   <= '0;
      end else begin
        if (w_req_fire) r_issue_ptr <= r_issue_ptr + 1'b1;
        if (w_rd_fire)  r_ret_ptr   <= r_ret_ptr + 1'b1;
      end
      // Pipe returns in issue order, so ret_ptr is the tag.
      if (w_rd_fire) begin
        r_out <= '{data:              rdata_bits,
                   group_index:       r_ret_ptr,
                   last:              r_ret_ptr == r_inst.group_index,
                   instruction_index: r_inst.instruction_index};
        r_out_valid <= 1'b1;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && r_state == ST_IDLE) begin
      assert (!(rdata_valid && w_credit == '0));
    end
  end

  assign inst_ready            = w_inst_ready;
  assign req_valid             = w_req_valid;
  assign req_vs                = r_inst.vs;
  assign req_group_index       = r_issue_ptr;
  assign req_read_source       = r_inst.read_source;
  assign req_instruction_index = r_inst.instruction_index;
  assign rdata_ready           = ~r_out_valid | out_ready;
  assign out_valid             = r_out_valid;
  assign out_data              = r_out.data;
  assign out_group_index       = r_out.group_index;
  assign out_last              = r_out.last;
  assign out_instruction_index = r_out.instruction_index;
  assign done                  = r_done;

endmodule
